md_hilo_unit: RTL

- Multi-cycle multiply/divide unit with the architectural HI/LO registers.
- Sits directly downstream of the control-signal sorting stage and consumes its mult/div, signed-calc and HI/LO read/write controls, plus rs/rt operand values.
- Replaces the ALU-internal HI/LO path with an iterative engine.
- Raises a stall request so the pipeline/PC holds while the engine is busy.

---
 rtl/md_hilo_unit_if.sv | 37 +++
 rtl/md_hilo_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/md_hilo_unit_if.sv
// Operand/control bundle between the control-signal sorting stage and md_hilo_unit.
// The master side drives controls and operands; the slave side returns read data, status and debug state.
interface md_hilo_unit_if #(
    parameter int WIDTH = 32
);
    // Handshake: a control pulse counts only when stall is low in that cycle.
    // While stall is high, the sorting stage keeps the same control and operands
    // until stall drops; it must not treat that instruction as retired.
    // A start (ALU_mult/ALU_div) is taken on the first clock edge where the unit is idle.
    logic             ALU_mult;
    logic             ALU_div;
    logic             ALU_signed_cal;
    logic             ALU_write_HI;
    logic             ALU_write_LO;
    logic             ALU_read_HI;
    logic             ALU_read_LO;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] rdata;
    logic             busy;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       state_dbg;

    modport master (
        output ALU_mult, ALU_div, ALU_signed_cal, ALU_write_HI, ALU_write_LO,
        output ALU_read_HI, ALU_read_LO, a, b,
        input  rdata, busy, stall, hi, lo, state_dbg
    );

    modport slave (
        input  ALU_mult, ALU_div, ALU_signed_cal, ALU_write_HI, ALU_write_LO,
        input  ALU_read_HI, ALU_read_LO, a, b,
        output rdata, busy, stall, hi, lo, state_dbg
    );
endinterface

// File: rtl/md_hilo_unit.sv
// Iterative multiply/divide engine that owns the HI/LO registers; stalls the pipeline while running.
// Optional macro MD_FAST_MULT_EN: single-cycle combinational multiply, divide stays iterative.
module md_hilo_unit #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          reset_n,
    md_hilo_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               op_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div0;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign a_neg = bus.ALU_signed_cal & bus.a[WIDTH-1];
    assign b_neg = bus.ALU_signed_cal & bus.b[WIDTH-1];
    assign a_mag = a_neg ? (~bus.a + 1'b1) : bus.a;
    assign b_mag = b_neg ? (~bus.b + 1'b1) : bus.b;

    // Multiply: low half of acc holds the remaining multiplier bits, high half the partial sum.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : {(WIDTH+1){1'b0}});

    // Divide: high half is the partial remainder, low half shifts the dividend out and the quotient in.
    // A set top bit of the difference means the trial subtraction borrowed.
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, mb};

    assign prod_fix = neg_res ? (~acc + 1'b1) : acc;
    assign quo_fix  = div0 ? {WIDTH{1'b1}} :
                      (neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0]);
    assign rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

`ifdef MD_FAST_MULT_EN
    logic signed [2*WIDTH-1:0] fa;
    logic signed [2*WIDTH-1:0] fb;
    logic signed [2*WIDTH-1:0] fp;
    assign fa = {{WIDTH{a_neg}}, bus.a};
    assign fb = {{WIDTH{b_neg}}, bus.b};
    assign fp = fa * fb;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            ma      <= '0;
            mb      <= '0;
            acc     <= '0;
            cnt     <= '0;
            op_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ALU_mult) begin
`ifdef MD_FAST_MULT_EN
                        hi_q <= fp[2*WIDTH-1:WIDTH];
                        lo_q <= fp[WIDTH-1:0];
`else
                        ma      <= a_mag;
                        mb      <= b_mag;
                        acc     <= {{WIDTH{1'b0}}, b_mag};
                        op_div  <= 1'b0;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        div0    <= 1'b0;
                        cnt     <= '0;
                        state   <= RUN;
`endif
                    end else if (bus.ALU_div) begin
                        ma      <= a_mag;
                        mb      <= b_mag;
                        acc     <= {{WIDTH{1'b0}}, a_mag};
                        op_div  <= 1'b1;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        div0    <= (bus.b == '0);
                        cnt     <= '0;
                        state   <= RUN;
                    end else if (bus.ALU_write_HI) begin
                        hi_q <= bus.a;
                    end else if (bus.ALU_write_LO) begin
                        lo_q <= bus.a;
                    end
                end
                RUN: begin
                    if (op_div) begin
                        if (div_diff[WIDTH]) begin
                            acc <= {acc[2*WIDTH-2:0], 1'b0};
                        end else begin
                            acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (op_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.stall     = bus.busy & (bus.ALU_mult | bus.ALU_div | bus.ALU_write_HI |
                                       bus.ALU_write_LO | bus.ALU_read_HI | bus.ALU_read_LO);
    assign bus.rdata     = bus.ALU_read_HI ? hi_q : (bus.ALU_read_LO ? lo_q : '0);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.state_dbg = state;
endmodule
